sbus_arbiter: RTL
=================

Name: sbus_arbiter

Overview:
Round-robin master-side arbiter for the shared register bus (rd_addr / rd_data / wr_addr / wr_data). N requesters (CPU core, DMA, debug bridge) issue single read or write transactions. The arbiter serialises them onto the bus in front of peripherals such as the UART, holds read addresses for the bus read latency, samples the resolved read data and returns it with a one-cycle ack.

Parameters:
XLEN, 32, bus address/data width
N_MST, 4, number of requesters (2..16)
RD_LAT, 1, cycles from rd_addr launch to valid rd_data on bus (0..7)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
m_req_i  in  N_MST  per-master request
m_we_i  in  N_MST  per-master 1=write, 0=read
m_addr_i  in  N_MST*XLEN  per-master address, master k at bits [k*XLEN +: XLEN]
m_wdata_i  in  N_MST*XLEN  per-master write data, same packing
m_ack_o  out  N_MST  one-hot completion pulse
m_rdata_o  out  XLEN  read data, valid only while an ack bit is high for a read
rd_addr_o  out  XLEN  bus read address, 0 = idle
rd_data_i  in  XLEN  resolved bus read data
wr_addr_o  out  XLEN  bus write address, 0 = idle
wr_data_o  out  XLEN  bus write data

Behaviour:
- Reset (async, immediate): all outputs 0, state IDLE, rr pointer 0, latched payload 0.
- All outputs are registered. Address 0 means bus idle. A request to address 0 is still sequenced and acked; its rdata is undefined.
- FSM states: IDLE, WR, RD, DONE.
- IDLE:
  - If any m_req_i bit is set, the winner is the first set bit at or after the pointer, wrapping modulo N_MST.
  - Latch winner index, we, addr and wdata.
  - Go to WR if we=1, else RD. Load the hold counter with RD_LAT.
  - If no request, stay in IDLE with bus outputs 0.
- WR: wr_addr_o/wr_data_o carry the latched values for exactly 1 cycle, then DONE.
- RD:
  - rd_addr_o carries the latched address for RD_LAT+1 consecutive cycles. The counter decrements each cycle.
  - On the cycle the counter is 0: capture rd_data_i, go to DONE.
- DONE:
  - All bus outputs 0. m_ack_o[winner]=1 for exactly this cycle.
  - m_rdata_o = captured data for reads, 0 for writes.
  - Pointer = (winner+1) mod N_MST. Next state IDLE.
- Latency from the IDLE cycle that samples req to ack: write 2 cycles; read RD_LAT+2 cycles.
- Minimum spacing between grants: write 3 cycles; read RD_LAT+3 cycles.
- Handshake rules:
  - The payload is latched at grant, so masters need hold it only through the grant cycle.
  - m_req_i still high in the IDLE cycle after ack is a new request.
  - Dropping req after grant does not cancel the transaction; the ack still pulses.
- Simultaneous requests resolve purely by rotating priority. No master waits more than N_MST-1 transactions.
- Never more than one m_ack_o bit high. wr_addr_o and rd_addr_o are never both nonzero.
- Reset mid-transaction: abort with no ack. After release, arbitration restarts at master 0.

Decomposition:
- Package sbus_arb_pkg:
  - state enum (IDLE, WR, RD, DONE)
  - SBUS_IDLE_ADDR = 0
  - function clog2-based index width
- Sub-module rr_pick: combinational rotating-priority picker (req vector, pointer) -> (valid, index). Instantiated once. The FSM, counter, pointer and payload registers live in sbus_arbiter.

Test Plan:
- Write, N_MST=4, RD_LAT=1: m2 req, we=1, addr 0x4000_0004, wdata 0x0000_00A5 -> next cycle wr_addr_o=0x4000_0004, wr_data_o=0xA5 for exactly 1 cycle; following cycle m_ack_o=4'b0100; rd_addr_o stays 0 throughout.
- Read: m0 reads 0x4000_0008; bus model returns 0x1234_5678 one cycle after address -> rd_addr_o=0x4000_0008 for 2 cycles, then m_ack_o=4'b0001 with m_rdata_o=0x1234_5678. Repeat with RD_LAT=3 -> address held 4 cycles.
- All four masters assert writes together after reset and hold req -> acks in order m0, m1, m2, m3, m0, spaced 3 cycles apart.
- m1 and m3 request continuously, pointer starting at 2 -> grants alternate m3, m1, m3, m1; m0 and m2 never acked.
- Master drops req the cycle after grant -> transaction completes and ack still pulses. Master keeps req high after ack -> re-granted only after the other pending masters.
- rst_i pulsed during the 2nd RD hold cycle -> rd_addr_o and m_ack_o go to 0 immediately, no ack is issued. After release, m0 and m2 requesting -> m0 served first.

Source files
------------

// File: rtl/sbus_arb_pkg.sv
// Shared types and constants for the shared register bus arbiter.
package sbus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        DONE
    } state_e;

    localparam int unsigned SBUS_IDLE_ADDR = 0;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sbus_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr_i, wrapping.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    always_comb begin
        int unsigned k;
        valid_o = 1'b0;
        idx_o   = '0;
        k       = 0;
        for (int unsigned i = 0; i < N; i++) begin
            k = (32'(ptr_i) + i) % N;
            if (!valid_o && req_i[IW'(k)]) begin
                valid_o = 1'b1;
                idx_o   = IW'(k);
            end
        end
    end

endmodule

// File: rtl/sbus_arbiter.sv
// Round-robin master-side arbiter serialising single read/write transactions
// onto the shared register bus, returning a one-cycle ack per transaction.
module sbus_arbiter
    import sbus_arb_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned N_MST  = 4,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_MST-1:0]      m_req_i,
    input  logic [N_MST-1:0]      m_we_i,
    input  logic [N_MST*XLEN-1:0] m_addr_i,
    input  logic [N_MST*XLEN-1:0] m_wdata_i,
    output logic [N_MST-1:0]      m_ack_o,
    output logic [XLEN-1:0]       m_rdata_o,
    output logic [XLEN-1:0]       rd_addr_o,
    input  logic [XLEN-1:0]       rd_data_i,
    output logic [XLEN-1:0]       wr_addr_o,
    output logic [XLEN-1:0]       wr_data_o
);

    localparam int unsigned IW = idx_width(N_MST);
    localparam logic [XLEN-1:0] IDLE_ADDR = XLEN'(SBUS_IDLE_ADDR);

    state_e           state_q;
    logic [IW-1:0]    ptr_q;
    logic [IW-1:0]    ptr_d;
    logic [IW-1:0]    win_q;
    logic [2:0]       cnt_q;
    logic [N_MST-1:0] ack_q;
    logic [XLEN-1:0]  rdata_q;
    logic [XLEN-1:0]  rd_addr_q;
    logic [XLEN-1:0]  wr_addr_q;
    logic [XLEN-1:0]  wr_data_q;

    logic             pick_valid;
    logic [IW-1:0]    pick_idx;
    logic [XLEN-1:0]  addr_a  [N_MST];
    logic [XLEN-1:0]  wdata_a [N_MST];

    for (genvar k = 0; k < N_MST; k++) begin : g_unpack
        assign addr_a[k]  = m_addr_i[k*XLEN +: XLEN];
        assign wdata_a[k] = m_wdata_i[k*XLEN +: XLEN];
    end

    rr_pick #(
        .N  (N_MST),
        .IW (IW)
    ) u_pick (
        .req_i   (m_req_i),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign ptr_d = (win_q == IW'(N_MST - 1)) ? '0 : win_q + 1'b1;

    // The bus output registers double as the latched payload: they are loaded
    // at grant so the address appears on the bus the cycle after sampling.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            cnt_q     <= '0;
            ack_q     <= '0;
            rdata_q   <= '0;
            rd_addr_q <= IDLE_ADDR;
            wr_addr_q <= IDLE_ADDR;
            wr_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q   <= '0;
                    rdata_q <= '0;
                    if (pick_valid) begin
                        win_q <= pick_idx;
                        cnt_q <= 3'(RD_LAT);
                        if (m_we_i[pick_idx]) begin
                            wr_addr_q <= addr_a[pick_idx];
                            wr_data_q <= wdata_a[pick_idx];
                            state_q   <= WR;
                        end else begin
                            rd_addr_q <= addr_a[pick_idx];
                            state_q   <= RD;
                        end
                    end
                end
                WR: begin
                    wr_addr_q <= IDLE_ADDR;
                    wr_data_q <= '0;
                    rdata_q   <= '0;
                    ack_q     <= N_MST'(1) << win_q;
                    state_q   <= DONE;
                end
                RD: begin
                    if (cnt_q == '0) begin
                        rd_addr_q <= IDLE_ADDR;
                        rdata_q   <= rd_data_i;
                        ack_q     <= N_MST'(1) << win_q;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    ack_q   <= '0;
                    rdata_q <= '0;
                    ptr_q   <= ptr_d;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_ack_o   = ack_q;
    assign m_rdata_o = rdata_q;
    assign rd_addr_o = rd_addr_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;

endmodule
